// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single write / dual read port of registerFile
// between requester A (CPU datapath) and requester B (debug/loader).
// Every granted access is one 3-cycle transaction: IDLE -> ACCESS -> RESP.
// Optional feature macro: ARB_LOCK_EN. When it is defined, an owner holding
// x_lock re-grants back-to-back at 2 cycles per transaction.
module regfile_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 4,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              b_req,
   input  logic              a_we,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] a_dst,
   input  logic [ADDR_W-1:0] b_dst,
   input  logic [ADDR_W-1:0] a_src,
   input  logic [ADDR_W-1:0] b_src,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic              a_lock,
   input  logic              b_lock,
   output logic              a_gnt,
   output logic              b_gnt,
   output logic              a_done,
   output logic              b_done,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              rf_writeEn,
   output logic [DATA_W-1:0] rf_writeData,
   output logic [ADDR_W-1:0] rf_dstAddr,
   output logic [ADDR_W-1:0] rf_srcAddr,
   input  logic [DATA_W-1:0] rf_readData1,
   input  logic [DATA_W-1:0] rf_readData2
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;   // 0 = A, 1 = B
   logic              last_q,  last_d;    // requester granted most recently
   logic              load;               // latch the selected requester's fields
   logic              sel_b;              // requester whose fields are latched
   logic              we_q;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_dst, sel_src;
   logic [DATA_W-1:0] sel_wdata;

`ifndef ARB_LOCK_EN
   // Lock inputs exist on the port list but have no effect in this build.
   logic unused_lock;
   assign unused_lock = a_lock ^ b_lock;
`endif

   // Next-state, winner selection and field-latch control.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      load    = 1'b0;
      sel_b   = owner_q;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               if (a_req && b_req)
                  sel_b = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
               else
                  sel_b = b_req;
               load    = 1'b1;
               owner_d = sel_b;
               last_d  = sel_b;
               state_d = ACCESS;
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            state_d = IDLE;
`ifdef ARB_LOCK_EN
            // Locked owner keeps the port; the tie pointer is left alone.
            if (owner_q ? (b_lock && b_req) : (a_lock && a_req)) begin
               load    = 1'b1;
               sel_b   = owner_q;
               state_d = ACCESS;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Field mux for the requester being latched.
   always_comb begin
      sel_we    = sel_b ? b_we    : a_we;
      sel_dst   = sel_b ? b_dst   : a_dst;
      sel_src   = sel_b ? b_src   : a_src;
      sel_wdata = sel_b ? b_wdata : a_wdata;
   end

   // State, pointer, latched request fields and read-data capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;   // first tie goes to A
         we_q         <= 1'b0;
         rf_writeData <= '0;
         rf_dstAddr   <= '0;
         rf_srcAddr   <= '0;
         rdata1       <= '0;
         rdata2       <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         if (load) begin
            we_q         <= sel_we;
            rf_writeData <= sel_wdata;
            rf_dstAddr   <= sel_dst;
            rf_srcAddr   <= sel_src;
         end
         // Capture at the end of ACCESS, same edge as the write: old dst value.
         if (state_q == ACCESS) begin
            rdata1 <= rf_readData1;
            rdata2 <= rf_readData2;
         end
      end
   end

   assign a_gnt  = (state_q != IDLE) && !owner_q;
   assign b_gnt  = (state_q != IDLE) &&  owner_q;
   assign a_done = (state_q == RESP) && !owner_q;
   assign b_done = (state_q == RESP) &&  owner_q;
   // Gated by reset so a transaction aborted in ACCESS never commits its write.
   assign rf_writeEn = (state_q == ACCESS) && we_q && !reset;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: registerFile model, scoreboard of expected read
// data pushed at issue and popped on done, directed steps in one initial block.
module tb_regfile_arbiter;
   localparam int DW = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, rf_clr;
   logic          a_req, b_req, a_we, b_we, a_lock, b_lock;
   logic [AW-1:0] a_dst, b_dst, a_src, b_src;
   logic [DW-1:0] a_wdata, b_wdata;

   logic          a_gnt, b_gnt, a_done, b_done, rf_we;
   logic [DW-1:0] rdata1, rdata2, rf_wdata, rd1, rd2;
   logic [AW-1:0] rf_dst, rf_src;

   logic          fp_a_gnt, fp_b_gnt, fp_a_done, fp_b_done, fp_we;
   logic [DW-1:0] fp_rdata1, fp_rdata2, fp_wdata, fp_rd1, fp_rd2;
   logic [AW-1:0] fp_dst, fp_src;

   regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0)) u_dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
      .a_dst(a_dst), .b_dst(b_dst), .a_src(a_src), .b_src(b_src),
      .a_wdata(a_wdata), .b_wdata(b_wdata), .a_lock(a_lock), .b_lock(b_lock),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
      .rdata1(rdata1), .rdata2(rdata2),
      .rf_writeEn(rf_we), .rf_writeData(rf_wdata),
      .rf_dstAddr(rf_dst), .rf_srcAddr(rf_src),
      .rf_readData1(rd1), .rf_readData2(rd2));

   // Fixed-priority instance sharing the same requests (tie-break check only).
   regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset),
      .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
      .a_dst(a_dst), .b_dst(b_dst), .a_src(a_src), .b_src(b_src),
      .a_wdata(a_wdata), .b_wdata(b_wdata), .a_lock(a_lock), .b_lock(b_lock),
      .a_gnt(fp_a_gnt), .b_gnt(fp_b_gnt), .a_done(fp_a_done), .b_done(fp_b_done),
      .rdata1(fp_rdata1), .rdata2(fp_rdata2),
      .rf_writeEn(fp_we), .rf_writeData(fp_wdata),
      .rf_dstAddr(fp_dst), .rf_srcAddr(fp_src),
      .rf_readData1(fp_rd1), .rf_readData2(fp_rd2));

   // registerFile model: combinational read, write on posedge.
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (rf_we) begin
         mem[rf_dst] <= rf_wdata;
      end
   end
   assign rd1    = mem[rf_dst];
   assign rd2    = mem[rf_src];
   assign fp_rd1 = mem[fp_dst];
   assign fp_rd2 = mem[fp_src];

   typedef struct {
      bit            is_b;
      logic [DW-1:0] r1;
      logic [DW-1:0] r2;
   } exp_t;
   exp_t          sbq[$];
   logic [DW-1:0] exp_regs [16];
   int            n_cmp = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected read data reflects the register contents before this write.
   task automatic push(input bit is_b, input bit we, input logic [AW-1:0] dst,
                       input logic [AW-1:0] src, input logic [DW-1:0] wd);
      exp_t e;
      e.is_b = is_b;
      e.r1   = exp_regs[dst];
      e.r2   = exp_regs[src];
      sbq.push_back(e);
      if (we) exp_regs[dst] = wd;
   endtask

   function automatic logic [63:0] out_vec();
      return 64'({a_gnt, b_gnt, a_done, b_done, rf_we, rf_wdata, rf_dst, rf_src, rdata1, rdata2});
   endfunction

   // Scoreboard pop on every done, plus per-cycle port invariants.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         check("one_gnt", 64'(a_gnt & b_gnt), 64'd0);
         check("we_outside_gnt", 64'(rf_we & ~(a_gnt | b_gnt)), 64'd0);
         check("fp_we_outside_gnt", 64'(fp_we & ~(fp_a_gnt | fp_b_gnt)), 64'd0);
         if (a_done || b_done) begin
            if (sbq.size() == 0) begin
               check("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = sbq.pop_front();
               check("done_owner", 64'(b_done), 64'(e.is_b));
               check("sb_rdata1", 64'(rdata1), 64'(e.r1));
               check("sb_rdata2", 64'(rdata2), 64'(e.r2));
            end
         end
      end
   end

   // One transaction from an idle DUT; reports latency, write-enable cycles
   // and cycles in which the other requester held a grant.
   task automatic run_txn(input bit is_b, input bit we, input logic [AW-1:0] dst,
                          input logic [AW-1:0] src, input logic [DW-1:0] wd,
                          output int lat, output int wen_cyc, output int other_gnt);
      if (is_b) begin
         b_we = we; b_dst = dst; b_src = src; b_wdata = wd; b_req = 1'b1;
      end else begin
         a_we = we; a_dst = dst; a_src = src; a_wdata = wd; a_req = 1'b1;
      end
      push(is_b, we, dst, src, wd);
      lat = 0; wen_cyc = 0; other_gnt = 0;
      @(negedge clk);
      while (!(is_b ? b_done : a_done) && lat < 10) begin
         @(negedge clk);
         lat++;
         if (rf_we) wen_cyc++;
         if (is_b ? a_gnt : b_gnt) other_gnt++;
      end
      a_req = 1'b0; b_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // Negedges until the main DUT pulses a done; a timeout counts as a failure.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(a_done || b_done) && n < 12);
      if (!(a_done || b_done)) check("done_timeout", 64'd0, 64'd1);
   endtask

   int lat, wen, oth, n;
   int gap_exp[4];
   bit own_exp[4];

   initial begin
      reset = 1'b1; rf_clr = 1'b1;
      a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
      a_dst = '0; b_dst = '0; a_src = '0; b_src = '0; a_wdata = '0; b_wdata = '0;
      for (int i = 0; i < 16; i++) exp_regs[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", out_vec(), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0; rf_clr = 1'b0;

      // Ties from reset: round-robin A,B,A,B; fixed priority A every time.
      a_we = 0; a_dst = 4'd1; a_src = 4'd2;
      b_we = 0; b_dst = 4'd3; b_src = 4'd4;
      for (int k = 0; k < 4; k++) push(k[0], 1'b0, k[0] ? 4'd3 : 4'd1, k[0] ? 4'd4 : 4'd2, '0);
      a_req = 1; b_req = 1;
      for (int k = 0; k < 4; k++) begin
         wait_done(n);
         check("t3_gap", 64'(n), 64'd3);
         check("t3_rr_b_done", 64'(b_done), 64'(k % 2));
         check("t3_fp_a_done", 64'({fp_a_done, fp_b_done}), 64'b10);
         if (k == 3) begin a_req = 0; b_req = 0; end
      end
      check("t3_fp_rdata", 64'({fp_rdata1, fp_rdata2}), 64'd0);
      @(posedge clk); #1;

      // Write then read back the same register.
      run_txn(1'b0, 1'b1, 4'd1, 4'd0, 16'd2, lat, wen, oth);
      check("t1_write_latency", 64'(lat), 64'd2);
      run_txn(1'b0, 1'b0, 4'd1, 4'd0, 16'd0, lat, wen, oth);
      check("t1_read_latency", 64'(lat), 64'd2);
      check("t1_rdata1", 64'(rdata1), 64'd2);

      // Read-before-write: old value returned, one write-enable cycle.
      run_txn(1'b0, 1'b1, 4'd3, 4'd1, 16'hBEEF, lat, wen, oth);
      check("t2_rdata1_old", 64'(rdata1), 64'h0000);
      check("t2_rdata2", 64'(rdata2), 64'd2);
      check("t2_we_cycles", 64'(wen), 64'd1);
      check("t2_reg3", 64'(mem[3]), 64'hBEEF);

      // Lone B read after A preloads regs 7 and 2.
      run_txn(1'b0, 1'b1, 4'd7, 4'd0, 16'd9, lat, wen, oth);
      run_txn(1'b0, 1'b1, 4'd2, 4'd0, 16'd4, lat, wen, oth);
      run_txn(1'b1, 1'b0, 4'd7, 4'd2, 16'd0, lat, wen, oth);
      check("t6_latency", 64'(lat), 64'd2);
      check("t6_a_gnt_seen", 64'(oth), 64'd0);
      check("t6_rdata", 64'({rdata1, rdata2}), 64'({16'd9, 16'd4}));

      // Reset sampled in ACCESS aborts the write and clears every output.
      a_we = 1; a_dst = 4'd5; a_src = 4'd0; a_wdata = 16'h1234; a_req = 1;
      @(posedge clk); #1;
      check("t4_gnt_in_access", 64'(a_gnt), 64'd1);
      reset = 1; a_req = 0; a_we = 0;
      @(negedge clk);
      check("t4_we_gated", 64'(rf_we), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_outputs_cleared", out_vec(), 64'd0);
      check("t4_reg5", 64'(mem[5]), 64'(exp_regs[5]));
      @(posedge clk); #1;
      reset = 0;

      // Lock: A holds lock with B pending; B only after A releases.
      a_we = 0; a_dst = 4'd1; a_src = 4'd3;
      b_we = 0; b_dst = 4'd7; b_src = 4'd2;
`ifdef ARB_LOCK_EN
      own_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
      gap_exp = '{3, 2, 2, 3};
`else
      own_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
      gap_exp = '{3, 3, 3, 3};
`endif
      for (int k = 0; k < 4; k++)
         push(own_exp[k], 1'b0, own_exp[k] ? 4'd7 : 4'd1, own_exp[k] ? 4'd2 : 4'd3, '0);
      a_lock = 1; a_req = 1; b_req = 1;
      for (int k = 0; k < 4; k++) begin
         wait_done(n);
         check("t5_gap", 64'(n), 64'(gap_exp[k]));
         check("t5_owner", 64'(b_done), 64'(own_exp[k]));
         if (k == 2) begin a_lock = 0; a_req = 0; end
         if (k == 3) b_req = 0;
      end
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      check("sb_leftover", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
